// File: rtl/mul_ctrl.sv
// Sequencer around the external 32x32 unsigned array multiplier: converts signed
// operands to magnitudes, captures the product, restores the sign into HI/LO.
module mul_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] m_x,
    output logic [31:0] m_y,
    input  logic [63:0] m_f,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, CAP, FIX} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        neg;
    logic [63:0] prod;

    // 0x80000000 maps to itself, which is already the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic s, input logic signed [31:0] v);
        return (s && v[31]) ? 32'(-v) : v;
    endfunction

    function automatic logic [63:0] fix64(input logic n, input logic signed [63:0] p);
        return n ? 64'(-p) : p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = CAP;
            CAP:     state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Registers load on entry to a state, so prod is valid in CAP and HI/LO in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_x  <= '0;
            m_y  <= '0;
            neg  <= 1'b0;
            prod <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        neg <= sgn & (a[31] ^ b[31]);
                        m_x <= mag32(sgn, a);
                        m_y <= mag32(sgn, b);
                    end
                end
                MUL: prod <= m_f;
                CAP: begin
                    {hi, lo} <= fix64(neg, prod);
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl; the multiplier is modelled as a plain product of m_x and m_y.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] m_x, m_y, hi, lo;
    logic [63:0] m_f;
    logic        busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign m_f = {32'd0, m_x} * {32'd0, m_y};

    mul_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .m_x(m_x), .m_y(m_y), .m_f(m_f),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in IDLE (cycle 0); returns at the falling edge of cycle 4.
    task automatic run_mul(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] emx, input logic [31:0] emy,
                           input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; sgn = s; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_c1_busy"}, 64'(busy), 64'd1);
        chk({tag, "_c1_mx"}, 64'(m_x), 64'(emx));
        chk({tag, "_c1_my"}, 64'(m_y), 64'(emy));
        @(negedge clk);
        chk({tag, "_c2_done"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_c3_done"}, 64'(done), 64'd1);
        chk({tag, "_c3_busy"}, 64'(busy), 64'd1);
        chk({tag, "_c3_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_c3_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, "_c4_busy"}, 64'(busy), 64'd0);
        chk({tag, "_c4_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_mx", 64'(m_x), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_mul("umax",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mul("smix",    1'b1, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_mul("umix",    1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
        run_mul("sminmin", 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run_mul("szero",   1'b1, 32'd0, 32'hFFFFFFF9, 32'd0, 32'd7, 32'h0, 32'h0);
        run_mul("snegneg", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 32'h1);
        run_mul("spos_neg", 1'b1, 32'd3, 32'hFFFFFFFE, 32'd3, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // Busy rules: restart and write while busy are dropped
        start = 1'b1; sgn = 1'b0; a = 32'd7; b = 32'd6;
        @(negedge clk);
        chk("busy_c1_busy", 64'(busy), 64'd1);
        chk("busy_c1_mx", 64'(m_x), 64'd7);
        start = 1'b1; a = 32'd9;
        @(negedge clk);
        chk("busy_c2_mx", 64'(m_x), 64'd7);
        chk("busy_c2_done", 64'(done), 64'd0);
        start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        hi_we = 1'b0;
        chk("busy_c3_done", 64'(done), 64'd1);
        chk("busy_c3_lo", 64'(lo), 64'd42);
        chk("busy_c3_hi", 64'(hi), 64'd0);
        @(negedge clk);
        chk("busy_c4_busy", 64'(busy), 64'd0);
        chk("busy_c4_done", 64'(done), 64'd0);
        chk("busy_c4_hi", 64'(hi), 64'd0);
        start = 1'b1; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_c5_mx", 64'(m_x), 64'd2);
        chk("busy_c5_my", 64'(m_y), 64'd3);
        @(negedge clk);
        chk("busy_c6_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("busy_c7_done", 64'(done), 64'd1);
        chk("busy_c7_lo", 64'(lo), 64'd6);
        @(negedge clk);
        chk("busy_c8_done", 64'(done), 64'd0);

        // HI/LO writes in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("wr_hi", 64'(hi), 64'h1234);
        chk("wr_done_hi", 64'(done), 64'd0);
        lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("wr_lo", 64'(lo), 64'h5678);
        chk("wr_hi_keep", 64'(hi), 64'h1234);
        chk("wr_done_lo", 64'(done), 64'd0);

        // Start and write together: write lands, then the product overwrites it
        start = 1'b1; sgn = 1'b0; a = 32'd4; b = 32'd5; hi_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("sw_c1_hi", 64'(hi), 64'hABCD);
        @(negedge clk);
        @(negedge clk);
        chk("sw_c3_hi", 64'(hi), 64'd0);
        chk("sw_c3_lo", 64'(lo), 64'd20);
        @(negedge clk);

        // Asynchronous reset mid-operation
        start = 1'b1; sgn = 1'b0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("arst_post_done", 64'(done), 64'd0);
            chk("arst_post_lo", 64'(lo), 64'd0);
        end
        chk("arst_post_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Sequential control stage wrapped around the team's combinational 32×32 unsigned array multiplier (`x`, `y` → 64-bit `f`). It accepts a signed or unsigned multiply request through a start/busy handshake and converts signed operands to magnitudes. It drives the multiplier, registers its product, applies sign correction, and holds the result in architectural HI/LO registers. It sits between the instruction datapath (upstream) and the multiplier (downstream), in the same way a MIPS-style HI/LO unit does.

## Interface
Parameters: none; all widths are fixed at 32/64.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a multiply; accepted only when `busy`=0.
- `sgn`  in  1  — 1 = signed (two's complement) multiply, 0 = unsigned; sampled with `start`.
- `a`  in  32  — multiplicand; sampled with `start`.
- `b`  in  32  — multiplier; sampled with `start`.
- `hi_we`  in  1  — write `wdata` to HI; honoured only when `busy`=0.
- `lo_we`  in  1  — write `wdata` to LO; honoured only when `busy`=0.
- `wdata`  in  32  — HI/LO write data.
- `m_x`  out  32  — operand to the multiplier's `x`; registered.
- `m_y`  out  32  — operand to the multiplier's `y`; registered.
- `m_f`  in  64  — product from the multiplier's `f`; combinational path, settles within one cycle.
- `busy`  out  1  — high from the cycle after acceptance until the result is written.
- `done`  out  1  — one-cycle pulse when HI/LO receive a new product.
- `hi`  out  32  — HI register, upper product word.
- `lo`  out  32  — LO register, lower product word.

## Operation
FSM states: IDLE, MUL, CAP, FIX.

- **IDLE**
  - `start`=1 → latch `neg` = `sgn` & (`a`[31] ^ `b`[31]).
  - Load `m_x` = (`sgn` & `a`[31]) ? −`a` : `a`, and `m_y` the same way from `b`.
  - Go to MUL.
  - Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
- **MUL**: the multiplier evaluates `m_x`·`m_y`; go to CAP.
- **CAP**: `prod` ← `m_f` (64-bit register); go to FIX.
- **FIX**
  - {`hi`,`lo`} ← `neg` ? −`prod` (64-bit two's complement) : `prod`.
  - Assert `done`; go to IDLE.
- **HI/LO writes**
  - In IDLE, `hi_we`/`lo_we` update the respective register.
  - If `start` and a write occur in the same cycle, both take effect; the write value is later overwritten by the product.
  - Writes in any other state are dropped.
- `start` while `busy`=1 is ignored: no queueing, and `a`/`b`/`sgn` are not resampled.
- `m_x`/`m_y` hold their last values after completion.

## Timing
- Reset (asynchronous, any state) → state IDLE; `m_x`, `m_y`, `prod`, `hi`, `lo`, `neg` = 0; `busy`=0; `done`=0.
  - An in-flight multiply is discarded; HI/LO are not updated from it.
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1: `busy`=1, `m_x`/`m_y` valid.
- Cycle 2: `prod` captured.
- Cycle 3: `hi`/`lo` valid, `done`=1, `busy`=1.
  - `busy` = (state ≠ IDLE); it is also high during the FIX cycle.
- Cycle 4: `busy`=0; a new `start` may be accepted this cycle. Back-to-back throughput is one multiply per 4 cycles.
- `done` is registered and lasts exactly one cycle.
- A `start` held high continuously is re-accepted in every IDLE cycle.
- The `m_f` → `prod` path is one full clock period; no other combinational input→output paths exist.

## Test plan
1. **Unsigned max**
   - Stimulus: `sgn`=0, `a`=`b`=0xFFFFFFFF.
   - Required: `done` in cycle 3; `hi`=0xFFFFFFFE, `lo`=0x00000001.
2. **Signed mixed**
   - Stimulus: `sgn`=1, `a`=0xFFFFFFFD (−3), `b`=5.
   - Required: `m_x`=3, `m_y`=5 in cycle 1; {`hi`,`lo`}=0xFFFFFFFF_FFFFFFF1.
   - Stimulus: repeat with `sgn`=0.
   - Required: `hi`=0x00000004, `lo`=0xFFFFFFF1.
3. **Signed min×min**
   - Stimulus: `sgn`=1, `a`=`b`=0x80000000.
   - Required: `hi`=0x40000000, `lo`=0; a zero operand with a negative sign gives 0, not −0 artefacts.
4. **Busy rules**
   - Stimulus: start 7×6; in cycle 1 pulse `start` with `a`=9; in cycle 2 pulse `hi_we` with 0xDEAD.
   - Required: result `lo`=42, `hi`=0; a single `done` pulse; the second start and the write are ignored.
   - Stimulus: in cycle 4, `start` 2×3.
   - Required: accepted; `lo`=6 in cycle 7.
5. **HI/LO writes**
   - Stimulus: in IDLE, write `hi`=0x1234, `lo`=0x5678.
   - Required: both visible the next cycle; `done` stays 0.
6. **Reset mid-operation**
   - Stimulus: start 2×3, then assert `rst_n`=0 in cycle 2 (asynchronously, between edges).
   - Required: `busy`, `done`, `hi`, `lo` go to 0 immediately; after release there is no `done` pulse and `lo` remains 0.
